// File: rtl/sync_ram_if.sv
// Port bundle for sync_ram: write port, read port, clear request and status.
// The master drives requests; the slave (the RAM) returns read data and status.
interface sync_ram_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
);
    logic              clr;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;
    logic              re;
    logic [AWIDTH-1:0] raddr;
    logic [DWIDTH-1:0] rdata;
    logic              rvalid;
    logic              busy;

    modport master (
        output clr, we, waddr, wdata, re, raddr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  clr, we, waddr, wdata, re, raddr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/sync_ram.sv
// Simple-dual-port synchronous RAM with registered read, selectable collision
// behaviour and a hardware sweep that zeroes the array after reset or on request.
module sync_ram #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned AWIDTH     = 5,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input logic       clk,
    input logic       rst_,
    sync_ram_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AWIDTH;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_waddr = bus.waddr;
        mem_wdata = bus.wdata;

        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == {AWIDTH{1'b1}}) begin
                    state_d = StReady;
                    busy_d  = 1'b0;
                end
            end
            StReady: begin
                mem_we = bus.we;
                if (bus.re) begin
                    rvalid_d = 1'b1;
                    // Write-first forwards the incoming word on a same-address collision.
                    if ((RD_MODE != 0) && bus.we && (bus.waddr == bus.raddr)) begin
                        rdata_d = bus.wdata;
                    end else begin
                        rdata_d = mem[bus.raddr];
                    end
                end
                if (bus.clr) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            if (CLR_ON_RST != 0) begin
                state_q <= StClear;
            end else begin
                state_q <= StReady;
            end
            clr_cnt_q <= '0;
            busy_q    <= (CLR_ON_RST != 0);
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // The array carries no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_sync_ram.sv
// Bench for sync_ram: two 32x8 instances (read-first and write-first) share stimulus,
// a third 8x16 instance comes out of reset without a sweep.
module tb_sync_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       clr, we, re;
    logic [4:0] waddr, raddr;
    logic [7:0] wdata;
    logic        c_we, c_re;
    logic [2:0]  c_waddr, c_raddr;
    logic [15:0] c_wdata;

    sync_ram_if #(.DWIDTH(8), .AWIDTH(5)) b0 ();
    sync_ram_if #(.DWIDTH(8), .AWIDTH(5)) b1 ();
    sync_ram_if #(.DWIDTH(16), .AWIDTH(3)) b2 ();

    assign b0.clr = clr;  assign b0.we = we;  assign b0.waddr = waddr;
    assign b0.wdata = wdata;  assign b0.re = re;  assign b0.raddr = raddr;
    assign b1.clr = clr;  assign b1.we = we;  assign b1.waddr = waddr;
    assign b1.wdata = wdata;  assign b1.re = re;  assign b1.raddr = raddr;
    assign b2.clr = 1'b0;  assign b2.we = c_we;  assign b2.waddr = c_waddr;
    assign b2.wdata = c_wdata;  assign b2.re = c_re;  assign b2.raddr = c_raddr;

    sync_ram #(.DWIDTH(8), .AWIDTH(5), .RD_MODE(0), .CLR_ON_RST(1)) dut0 (
        .clk(clk), .rst_(rst_a), .bus(b0));
    sync_ram #(.DWIDTH(8), .AWIDTH(5), .RD_MODE(1), .CLR_ON_RST(1)) dut1 (
        .clk(clk), .rst_(rst_a), .bus(b1));
    sync_ram #(.DWIDTH(16), .AWIDTH(3), .RD_MODE(0), .CLR_ON_RST(0)) dut2 (
        .clk(clk), .rst_(rst_b), .bus(b2));

    // Reference model: contents, pending sweep length and expected read outputs.
    logic [7:0] m_mem [32];
    int         m_busy;
    logic [7:0] m_rd0, m_rd1;
    logic       m_rv;
    int         passed = 0;
    int         total = 0;

    task automatic reset_model();
        m_busy = 32; m_rd0 = 8'h00; m_rd1 = 8'h00; m_rv = 1'b0;
    endtask

    task automatic drive(input logic c, input logic w, input logic [4:0] wa,
                         input logic [7:0] wd, input logic r, input logic [4:0] ra);
        clr = c; we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
    endtask

    // One clock edge, then advance the model with the inputs that edge sampled.
    task automatic cycle();
        logic c, w, r;
        logic [4:0] wa, ra;
        logic [7:0] wd;
        c = clr; w = we; r = re; wa = waddr; ra = raddr; wd = wdata;
        @(posedge clk);
        #1;
        if (m_busy > 0) begin
            m_rv = 1'b0;
            m_busy--;
            if (m_busy == 0) foreach (m_mem[i]) m_mem[i] = 8'h00;
        end else begin
            if (r) begin
                m_rd0 = m_mem[ra];
                m_rd1 = (w && wa == ra) ? wd : m_mem[ra];
            end
            m_rv = r;
            if (w) m_mem[wa] = wd;
            if (c) m_busy = 32;
        end
    endtask

    task automatic test_reset();
        int busy_edges;
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_model();
        total++; if (b0.busy !== 1'b1) $display("FAIL rst busy: got %b want 1", b0.busy); else passed++;
        total++; if (b0.rvalid !== 1'b0) $display("FAIL rst rvalid: got %b want 0", b0.rvalid); else passed++;
        total++; if (b0.rdata !== 8'h00) $display("FAIL rst rdata0: got %h want 00", b0.rdata); else passed++;
        total++; if (b1.rdata !== 8'h00) $display("FAIL rst rdata1: got %h want 00", b1.rdata); else passed++;
        rst_a = 1'b1;
        busy_edges = 0;
        for (int k = 0; k < 33; k++) begin
            if (b0.busy === 1'b1) busy_edges++;
            cycle();
            total++; if (b0.busy !== (m_busy > 0)) $display("FAIL sweep busy k=%0d: got %b want %b", k, b0.busy, m_busy > 0); else passed++;
            total++; if (b0.rvalid !== m_rv) $display("FAIL sweep rvalid k=%0d: got %b want %b", k, b0.rvalid, m_rv); else passed++;
        end
        total++; if (busy_edges != 32) $display("FAIL sweep length: got %0d want 32", busy_edges); else passed++;
        total++; if (b0.rdata !== 8'h00 || b0.rvalid !== 1'b1) $display("FAIL first read: got %h/%b want 00/1", b0.rdata, b0.rvalid); else passed++;
    endtask

    task automatic test_write_read();
        logic [7:0] want [3];
        logic [4:0] addr [3];
        want[0] = 8'hA5; want[1] = 8'h5A; want[2] = 8'hA5;
        addr[0] = 5'd3; addr[1] = 5'd31; addr[2] = 5'd3;
        drive(1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 5'd0);  cycle();
        drive(1'b0, 1'b1, 5'd31, 8'h5A, 1'b0, 5'd0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, addr[i]);
            cycle();
            total++; if (b0.rdata !== want[i] || b0.rvalid !== 1'b1) $display("FAIL wr rd %0d: got %h/%b want %h/1", i, b0.rdata, b0.rvalid, want[i]); else passed++;
        end
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        cycle();
        total++; if (b0.rvalid !== 1'b0 || b0.rdata !== 8'hA5) $display("FAIL wr rd idle: got %h/%b want a5/0", b0.rdata, b0.rvalid); else passed++;
    endtask

    task automatic test_collision();
        drive(1'b0, 1'b1, 5'd7, 8'h11, 1'b0, 5'd0); cycle();
        drive(1'b0, 1'b1, 5'd7, 8'h22, 1'b1, 5'd7); cycle();
        total++; if (b0.rdata !== 8'h11) $display("FAIL coll read-first: got %h want 11", b0.rdata); else passed++;
        total++; if (b1.rdata !== 8'h22) $display("FAIL coll write-first: got %h want 22", b1.rdata); else passed++;
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7); cycle();
        total++; if (b0.rdata !== 8'h22 || b1.rdata !== 8'h22) $display("FAIL coll reread: got %h,%h want 22,22", b0.rdata, b1.rdata); else passed++;
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0); cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 59) == 0, 1'(($urandom)), 5'($urandom), 8'($urandom),
                  1'($urandom), 5'($urandom));
            if (($urandom & 3) == 0) raddr = waddr;
            cycle();
            total++; if (b0.rdata !== m_rd0) $display("FAIL rand rdata0 k=%0d: got %h want %h", k, b0.rdata, m_rd0); else passed++;
            total++; if (b1.rdata !== m_rd1) $display("FAIL rand rdata1 k=%0d: got %h want %h", k, b1.rdata, m_rd1); else passed++;
            total++; if (b0.rvalid !== m_rv || b1.rvalid !== m_rv) $display("FAIL rand rvalid k=%0d: got %b,%b want %b", k, b0.rvalid, b1.rvalid, m_rv); else passed++;
            total++; if (b0.busy !== (m_busy > 0)) $display("FAIL rand busy k=%0d: got %b want %b", k, b0.busy, m_busy > 0); else passed++;
        end
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        for (int k = 0; k < 33 && m_busy > 0; k++) cycle();
    endtask

    task automatic test_soft_clear();
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b1, 5'(a), 8'hFF, 1'b0, 5'd0);
            cycle();
        end
        drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd4);
        cycle();
        total++; if (b0.rdata !== 8'hFF || b0.rvalid !== 1'b1 || b0.busy !== 1'b1) $display("FAIL clr read: got %h/%b/%b want ff/1/1", b0.rdata, b0.rvalid, b0.busy); else passed++;
        for (int k = 0; k < 32; k++) begin
            drive(1'($urandom), 1'b1, 5'($urandom), 8'($urandom), 1'b1, 5'($urandom));
            cycle();
            total++; if (b0.busy !== (k < 31)) $display("FAIL clr busy k=%0d: got %b want %b", k, b0.busy, k < 31); else passed++;
            total++; if (b0.rvalid !== 1'b0) $display("FAIL clr rvalid k=%0d: got %b want 0", k, b0.rvalid); else passed++;
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a));
            cycle();
            total++; if (b0.rdata !== 8'h00 || b0.rvalid !== 1'b1) $display("FAIL clr zero a=%0d: got %h/%b want 00/1", a, b0.rdata, b0.rvalid); else passed++;
        end
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        cycle();
    endtask

    task automatic test_reset_mid_sweep();
        drive(1'b0, 1'b1, 5'd9, 8'h3C, 1'b0, 5'd0); cycle();
        drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd9); cycle();
        total++; if (b0.rdata !== 8'h3C || b0.rvalid !== 1'b1) $display("FAIL mid pre-clear read: got %h/%b want 3c/1", b0.rdata, b0.rvalid); else passed++;
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd0);
        repeat (10) cycle();
        rst_a = 1'b0;
        #2;
        reset_model();
        total++; if (b0.rdata !== 8'h00 || b0.rvalid !== 1'b0 || b0.busy !== 1'b1) $display("FAIL mid reset: got %h/%b/%b want 00/0/1", b0.rdata, b0.rvalid, b0.busy); else passed++;
        rst_a = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            total++; if (b0.busy !== (m_busy > 0) || b0.rvalid !== 1'b0) $display("FAIL mid sweep k=%0d: got busy %b rvalid %b want %b/0", k, b0.busy, b0.rvalid, m_busy > 0); else passed++;
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(31 - a));
            cycle();
            total++; if (b0.rdata !== 8'h00 || b0.rvalid !== 1'b1) $display("FAIL mid zero a=%0d: got %h/%b want 00/1", 31 - a, b0.rdata, b0.rvalid); else passed++;
        end
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    endtask

    task automatic test_no_clr_on_rst();
        logic [15:0] m2 [8];
        c_we = 1'b0; c_re = 1'b0; c_waddr = 3'd0; c_raddr = 3'd0; c_wdata = 16'h0;
        @(posedge clk);
        #1;
        total++; if (b2.busy !== 1'b0 || b2.rvalid !== 1'b0 || b2.rdata !== 16'h0) $display("FAIL noclr rst: got %b/%b/%h want 0/0/0000", b2.busy, b2.rvalid, b2.rdata); else passed++;
        rst_b = 1'b1;
        c_we = 1'b1; c_waddr = 3'd7; c_wdata = 16'hBEEF;
        @(posedge clk);
        #1;
        total++; if (b2.busy !== 1'b0 || b2.rvalid !== 1'b0) $display("FAIL noclr first edge: got busy %b rvalid %b want 0/0", b2.busy, b2.rvalid); else passed++;
        c_we = 1'b0; c_re = 1'b1; c_raddr = 3'd7;
        @(posedge clk);
        #1;
        total++; if (b2.rdata !== 16'hBEEF || b2.rvalid !== 1'b1) $display("FAIL noclr read: got %h/%b want beef/1", b2.rdata, b2.rvalid); else passed++;
        c_re = 1'b0;
        for (int a = 0; a < 8; a++) begin
            m2[a] = 16'($urandom);
            c_we = 1'b1; c_waddr = 3'(a); c_wdata = m2[a];
            @(posedge clk);
            #1;
        end
        c_we = 1'b0; c_re = 1'b1;
        for (int a = 0; a < 8; a++) begin
            c_raddr = 3'(a + 5);
            @(posedge clk);
            #1;
            total++; if (b2.rdata !== m2[3'(a + 5)]) $display("FAIL noclr rd a=%0d: got %h want %h", a, b2.rdata, m2[3'(a + 5)]); else passed++;
        end
        c_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        c_we = 1'b0; c_re = 1'b0; c_waddr = 3'd0; c_raddr = 3'd0; c_wdata = 16'h0;
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        test_reset();
        test_write_read();
        test_collision();
        test_random();
        test_soft_clear();
        test_reset_mid_sweep();
        test_no_clr_on_rst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised synchronous simple-dual-port RAM. It replaces the asynchronous 32x8 bidirectional-bus memory with a clocked block that has:

- separate write and read ports, and a registered read with a valid strobe;
- a configurable read/write collision mode;
- a hardware clear sequencer that zeroes every location after reset or on request.

It sits between the CPU datapath and the memory, as the program/data store.

## Interface
- DWIDTH, 8, data word width in bits.
- AWIDTH, 5, address width; depth DEPTH = 2**AWIDTH (derived, not overridable).
- RD_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new data).
- CLR_ON_RST, 1, 1 = run the clear sweep after reset; 0 = come out of reset ready, contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- clr  in  1  single-cycle request to zero the whole array.
- we  in  1  write request.
- waddr  in  AWIDTH  write address.
- wdata  in  DWIDTH  write data.
- re  in  1  read request.
- raddr  in  AWIDTH  read address.
- rdata  out  DWIDTH  registered read data.
- rvalid  out  1  one-cycle pulse: rdata holds the data for a read accepted on the previous edge.
- busy  out  1  registered; 1 = clear sweep in progress, requests ignored.

## Operation
- State machine, two states:
  - CLEAR: sweep counter clr_cnt writes 0 to location clr_cnt on each edge, then increments. When clr_cnt == DEPTH-1, that edge writes the last location, clears busy and moves to READY.
  - READY: services the ports. A clr=1 sampled in READY loads clr_cnt=0, sets busy and moves to CLEAR.
- Reset (rst_ low, async):
  - state = CLEAR if CLR_ON_RST else READY;
  - clr_cnt = 0; busy = CLR_ON_RST; rdata = 0; rvalid = 0.
  - The array itself is not reset.
- Reset asserted mid-sweep aborts the sweep. After release it restarts from address 0.
- Accept rules:
  - Write accepted on an edge when we & ~busy: mem[waddr] <= wdata.
  - Read accepted when re & ~busy: rdata <= mem[raddr], and rvalid = 1 for the next cycle.
  - When busy = 1, we and re are ignored: no write, rvalid stays 0, rdata holds its value.
- Write and read in the same cycle are both accepted.
  - Different addresses: independent.
  - raddr == waddr: rdata = old contents if RD_MODE=0, wdata if RD_MODE=1.
- rdata holds its last value when no read is accepted. rvalid is 0 in any cycle not following an accepted read.
- clr together with we/re in READY:
  - the write and read of that edge complete normally; the read returns pre-clear data with rvalid.
  - busy rises on the same edge; the sweep later zeroes the written location.
- clr while busy = 1 is ignored (no restart).
- Addresses wrap naturally in AWIDTH bits; all addresses are valid.

## Timing
- Read latency 1 clock: re sampled at edge N, rdata/rvalid valid after edge N, for the cycle N..N+1.
- Write latency 0: a location written at edge N is readable by a read accepted at edge N+1. With RD_MODE=1 it is also readable at edge N.
- Back-to-back reads at full rate: rvalid stays high continuously for consecutive accepted reads.
- Clear sweep takes exactly DEPTH cycles.
  - After rst_ release with CLR_ON_RST=1: busy=1 through the DEPTH-th rising edge and 0 after it. The first accepted op is on edge DEPTH+1.
  - clr sampled at edge N: busy=1 after edge N, busy=0 after edge N+DEPTH.
- busy and rvalid come directly from flops, with no combinational path from inputs.

## Test plan
- Reset sweep, defaults (DWIDTH=8, AWIDTH=5): release rst_, hold re=1 raddr=0 -> busy high for exactly 32 edges, no rvalid during the sweep; first read after returns rdata=8'h00 with rvalid.
- Write/read: write 8'hA5 to addr 3, 8'h5A to addr 31; read 3, 31, 3 back-to-back -> rdata A5, 5A, A5 on consecutive cycles, rvalid high for 3 cycles then 0.
- Collision: addr 7 holds 8'h11; same cycle we=1 waddr=7 wdata=8'h22, re=1 raddr=7 -> RD_MODE=0 returns 11, RD_MODE=1 returns 22; a following read of 7 returns 22 in both modes.
- Soft clear: fill all 32 locations with 8'hFF, pulse clr together with re raddr=4 -> rvalid with FF next cycle, busy 32 cycles, writes during busy dropped, all locations read 00 afterwards.
- Reset mid-sweep: assert rst_ low 10 cycles into a clear, release -> rdata=0, rvalid=0 immediately; busy high for 32 cycles after release; all locations read 00.
- CLR_ON_RST=0, AWIDTH=3, DWIDTH=16: busy=0 after reset; write 16'hBEEF to addr 7 on the first edge, read addr 7 on the next edge -> rdata=BEEF one cycle later.
